// File: rtl/ext_ram_reader.sv
// ---------------------------------------------------------------------------
// ext_ram_reader
//
// Reads one 16-bit word from an external nibble-serial RAM per request.
// A transaction sends a read command nibble, the four address nibbles
// (least significant first), waits DELAY turnaround cycles and then
// collects four data nibbles (least significant first) before presenting
// the word for one cycle.
//
// Parameters
//   DELAY       RAM turnaround cycles between the last address nibble and
//               the first data nibble (legal range 1..31)
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst_n       synchronous active-low reset
//   req_valid   read request pending
//   req_addr    word address of the request
//   req_ready   high while idle; request accepted on req_valid && req_ready
//   addr_out    command/address nibble stream to the RAM
//   data_in     data nibble stream from the RAM
//   resp_valid  one-cycle pulse when resp_data holds a new word
//   resp_data   last word read
//   busy        high in every state except IDLE
// ---------------------------------------------------------------------------
module ext_ram_reader #(
  parameter int DELAY = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [15:0] req_addr,
  output logic        req_ready,
  output logic [3:0]  addr_out,
  input  logic [3:0]  data_in,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WAIT,
    DATA,
    RESP
  } state_t;

  localparam logic [3:0] READ_CMD  = 4'h1;
  localparam logic [4:0] WAIT_LAST = 5'(DELAY - 1);
  localparam logic [4:0] NIB_LAST  = 5'd3;

  state_t      state;
  logic [4:0]  count;
  logic [15:0] addr_shift;

  // All outputs are registered: each one is loaded on the edge that enters
  // the state in which it must be visible. The latched address is consumed
  // as a shift register so the next nibble to send is always in [3:0].
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= 5'd0;
      addr_shift <= 16'h0000;
      addr_out   <= 4'h0;
      resp_valid <= 1'b0;
      resp_data  <= 16'h0000;
      busy       <= 1'b0;
      req_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_shift <= req_addr;
            addr_out   <= READ_CMD;
            busy       <= 1'b1;
            req_ready  <= 1'b0;
            count      <= 5'd0;
            state      <= CMD;
          end
        end

        CMD: begin
          addr_out   <= addr_shift[3:0];
          addr_shift <= {4'h0, addr_shift[15:4]};
          count      <= 5'd0;
          state      <= ADDR;
        end

        // count tracks which address nibble is currently on addr_out.
        ADDR: begin
          if (count == NIB_LAST) begin
            addr_out <= 4'h0;
            count    <= 5'd0;
            state    <= WAIT;
          end else begin
            addr_out   <= addr_shift[3:0];
            addr_shift <= {4'h0, addr_shift[15:4]};
            count      <= count + 5'd1;
          end
        end

        WAIT: begin
          if (count == WAIT_LAST) begin
            count <= 5'd0;
            state <= DATA;
          end else begin
            count <= count + 5'd1;
          end
        end

        // Nibbles are written in place so the previous word stays intact
        // until the first nibble of the new one lands.
        DATA: begin
          case (count[1:0])
            2'd0:    resp_data[3:0]   <= data_in;
            2'd1:    resp_data[7:4]   <= data_in;
            2'd2:    resp_data[11:8]  <= data_in;
            default: resp_data[15:12] <= data_in;
          endcase
          if (count == NIB_LAST) begin
            count      <= 5'd0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            count <= count + 5'd1;
          end
        end

        RESP: begin
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end

        default: begin
          state      <= IDLE;
          count      <= 5'd0;
          addr_out   <= 4'h0;
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_ram_reader.sv
// ---------------------------------------------------------------------------
// tb_ext_ram_reader
//
// Directed bench for ext_ram_reader. The main instance (DELAY=7) talks to a
// behavioural serial RAM holding a preloaded 64K-word image; a second
// instance (DELAY=1) has its data pins driven directly so garbage can be
// placed around the data window.
// ---------------------------------------------------------------------------
module tb_ext_ram_reader;

  localparam int D      = 7;
  localparam int D_FAST = 1;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_ready;
  logic [3:0]  addr_out;
  logic [3:0]  data_in;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        busy;

  logic        fast_req_valid;
  logic [15:0] fast_req_addr;
  logic        fast_req_ready;
  logic [3:0]  fast_addr_out;
  logic [3:0]  fast_data_in;
  logic        fast_resp_valid;
  logic [15:0] fast_resp_data;
  logic        fast_busy;

  int pass_count;
  int check_count;

  ext_ram_reader #(.DELAY(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .addr_out   (addr_out),
    .data_in    (data_in),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  ext_ram_reader #(.DELAY(D_FAST)) dut_fast (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (fast_req_valid),
    .req_addr   (fast_req_addr),
    .req_ready  (fast_req_ready),
    .addr_out   (fast_addr_out),
    .data_in    (fast_data_in),
    .resp_valid (fast_resp_valid),
    .resp_data  (fast_resp_data),
    .busy       (fast_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial RAM model (RAM_ADDR_BITS=16, turnaround D). It waits for the
  // read command, collects four address nibbles, idles D cycles and then
  // drives four data nibbles; at all other times the data pins carry noise.
  logic [15:0] mem [0:65535];
  logic [1:0]  ram_state;
  int          ram_cnt;
  logic [15:0] ram_addr;
  logic [15:0] ram_word;

  always @(posedge clk) begin
    if (!rst_n) begin
      ram_state <= 2'd0;
      ram_cnt   <= 0;
      data_in   <= 4'($urandom);
    end else begin
      case (ram_state)
        2'd0: begin
          data_in <= 4'($urandom);
          if (addr_out == 4'h1) begin
            ram_state <= 2'd1;
            ram_cnt   <= 0;
          end
        end
        2'd1: begin
          data_in <= 4'($urandom);
          ram_addr[ram_cnt*4 +: 4] <= addr_out;
          if (ram_cnt == 3) begin
            ram_state <= 2'd2;
            ram_cnt   <= 0;
          end else begin
            ram_cnt <= ram_cnt + 1;
          end
        end
        2'd2: begin
          if (ram_cnt == D - 1) begin
            ram_word = mem[ram_addr];
            data_in   <= ram_word[3:0];
            ram_state <= 2'd3;
            ram_cnt   <= 1;
          end else begin
            data_in <= 4'($urandom);
            ram_cnt <= ram_cnt + 1;
          end
        end
        default: begin
          ram_word = mem[ram_addr];
          data_in <= ram_word[ram_cnt*4 +: 4];
          if (ram_cnt == 3) ram_state <= 2'd0;
          else ram_cnt <= ram_cnt + 1;
        end
      endcase
    end
  end

  // Expected {busy, req_ready, resp_valid, addr_out} k cycles after the
  // accept cycle (k=0 is the accepting IDLE cycle).
  function automatic logic [6:0] exp_vec(int k, logic [15:0] a, int d);
    logic [3:0] nib;
    logic       bsy;
    logic       rv;
    nib = 4'h0;
    if (k == 1) nib = 4'h1;
    else if (k >= 2 && k <= 5) nib = a[(k-2)*4 +: 4];
    bsy = (k >= 1 && k <= 10 + d);
    rv  = (k == 10 + d);
    return {bsy, !bsy, rv, nib};
  endfunction

  task automatic test_reset();
    rst_n          = 1'b0;
    req_valid      = 1'b0;
    req_addr       = 16'h0000;
    fast_req_valid = 1'b0;
    fast_req_addr  = 16'h0000;
    fast_data_in   = 4'h0;
    repeat (3) @(negedge clk);
    check_count++;
    if ({busy, req_ready, resp_valid, addr_out} !== 7'b0100000)
      $display("[TB] FAIL reset_ctrl got=%b exp=%b", {busy, req_ready, resp_valid, addr_out}, 7'b0100000);
    else pass_count++;
    check_count++;
    if (resp_data !== 16'h0000)
      $display("[TB] FAIL reset_data got=%h exp=0000", resp_data);
    else pass_count++;
    check_count++;
    if ({fast_busy, fast_req_ready, fast_resp_valid, fast_addr_out, fast_resp_data} !== {7'b0100000, 16'h0000})
      $display("[TB] FAIL reset_fast got=%h exp=%h",
               {fast_busy, fast_req_ready, fast_resp_valid, fast_addr_out, fast_resp_data}, {7'b0100000, 16'h0000});
    else pass_count++;
    rst_n = 1'b1;
  endtask

  // Request A5C3, RAM returns 1234: nibbles 1,3,C,5,A then resp at T+17.
  task automatic test_basic_read();
    logic [6:0] exp;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 16'hA5C3;
    for (int k = 0; k <= 18; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      exp = exp_vec(k, 16'hA5C3, D);
      check_count++;
      if ({busy, req_ready, resp_valid, addr_out} !== exp)
        $display("[TB] FAIL basic_cycle k=%0d got=%b exp=%b", k, {busy, req_ready, resp_valid, addr_out}, exp);
      else pass_count++;
      if (k == 17) begin
        check_count++;
        if (resp_data !== 16'h1234)
          $display("[TB] FAIL basic_data got=%h exp=1234", resp_data);
        else pass_count++;
      end
    end
  endtask

  // req_valid held high: 0000 then FFFF, one IDLE cycle between them.
  task automatic test_back_to_back();
    logic [6:0] exp;
    int         bad;
    bad = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 16'h0000;
    for (int k = 0; k <= 36; k++) begin
      if (k > 0) @(negedge clk);
      exp = (k < 18) ? exp_vec(k, 16'h0000, D) : exp_vec(k - 18, 16'hFFFF, D);
      if ({busy, req_ready, resp_valid, addr_out} !== exp) begin
        bad++;
        $display("[TB] FAIL b2b_cycle k=%0d got=%b exp=%b", k, {busy, req_ready, resp_valid, addr_out}, exp);
      end
      if (k == 17) begin
        check_count++;
        if (resp_data !== mem[16'h0000])
          $display("[TB] FAIL b2b_data0 got=%h exp=%h", resp_data, mem[16'h0000]);
        else pass_count++;
      end
      if (k == 35) begin
        check_count++;
        if (resp_data !== mem[16'hFFFF])
          $display("[TB] FAIL b2b_data1 got=%h exp=%h", resp_data, mem[16'hFFFF]);
        else pass_count++;
      end
      if (k == 1) req_addr = 16'hFFFF;
      if (k == 19) req_valid = 1'b0;
    end
    check_count++;
    if (bad != 0) $display("[TB] FAIL b2b_sequence got=%0d bad cycles exp=0", bad);
    else pass_count++;
  endtask

  // Reset mid-ADDR aborts the read silently; a fresh read then completes.
  task automatic test_reset_abort();
    logic [6:0] exp;
    int         bad;
    int         pulses;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 16'h1234;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_count++;
    if ({busy, req_ready, resp_valid, addr_out, resp_data} !== {7'b0100000, 16'h0000})
      $display("[TB] FAIL abort_reset got=%h exp=%h",
               {busy, req_ready, resp_valid, addr_out, resp_data}, {7'b0100000, 16'h0000});
    else pass_count++;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (resp_valid || busy) pulses++;
    end
    check_count++;
    if (pulses != 0) $display("[TB] FAIL abort_quiet got=%0d active cycles exp=0", pulses);
    else pass_count++;
    bad = 0;
    req_valid = 1'b1;
    req_addr  = 16'h4321;
    for (int k = 0; k <= 17; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      exp = exp_vec(k, 16'h4321, D);
      if ({busy, req_ready, resp_valid, addr_out} !== exp) bad++;
    end
    check_count++;
    if (bad != 0 || resp_data !== mem[16'h4321])
      $display("[TB] FAIL abort_fresh got=%0d bad/%h exp=0/%h", bad, resp_data, mem[16'h4321]);
    else pass_count++;
  endtask

  // Request inputs toggled randomly while busy must have no effect.
  task automatic test_busy_ignore();
    logic [6:0] exp;
    int         bad;
    bad = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 16'h9E27;
    for (int k = 0; k <= 17; k++) begin
      if (k > 0) @(negedge clk);
      exp = exp_vec(k, 16'h9E27, D);
      if ({busy, req_ready, resp_valid, addr_out} !== exp) bad++;
      if (k >= 1 && k <= 16) begin
        req_valid = 1'($urandom);
        req_addr  = 16'($urandom);
      end else if (k == 17) begin
        req_valid = 1'b0;
      end
    end
    check_count++;
    if (bad != 0) $display("[TB] FAIL ignore_sequence got=%0d bad cycles exp=0", bad);
    else pass_count++;
    check_count++;
    if (resp_data !== mem[16'h9E27])
      $display("[TB] FAIL ignore_data got=%h exp=%h", resp_data, mem[16'h9E27]);
    else pass_count++;
  endtask

  // 256 random reads against the preloaded image.
  task automatic test_random_reads();
    logic [6:0]  exp;
    logic [15:0] a;
    int          bad_seq;
    int          bad_data;
    bad_seq  = 0;
    bad_data = 0;
    for (int n = 0; n < 256; n++) begin
      a = 16'($urandom);
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = a;
      for (int k = 0; k <= 17; k++) begin
        if (k > 0) @(negedge clk);
        if (k == 1) req_valid = 1'b0;
        exp = exp_vec(k, a, D);
        if ({busy, req_ready, resp_valid, addr_out} !== exp) bad_seq++;
      end
      if (resp_data !== mem[a]) begin
        bad_data++;
        if (bad_data <= 4)
          $display("[TB] FAIL random_read addr=%h got=%h exp=%h", a, resp_data, mem[a]);
      end
    end
    check_count++;
    if (bad_seq != 0) $display("[TB] FAIL random_sequence got=%0d bad cycles exp=0", bad_seq);
    else pass_count++;
    check_count++;
    if (bad_data != 0) $display("[TB] FAIL random_data got=%0d bad words exp=0", bad_data);
    else pass_count++;
  endtask

  // DELAY=1: resp at T+11, data_in noise outside cycles 7..10 is ignored.
  task automatic test_delay_one();
    logic [6:0]  exp;
    logic [15:0] word;
    int          bad;
    word = 16'hBEEF;
    bad  = 0;
    @(negedge clk);
    fast_req_valid = 1'b1;
    fast_req_addr  = 16'h0001;
    fast_data_in   = 4'($urandom);
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) fast_req_valid = 1'b0;
      fast_data_in = (k >= 7 && k <= 10) ? word[(k-7)*4 +: 4] : 4'($urandom);
      exp = exp_vec(k, 16'h0001, D_FAST);
      if ({fast_busy, fast_req_ready, fast_resp_valid, fast_addr_out} !== exp) begin
        bad++;
        $display("[TB] FAIL fast_cycle k=%0d got=%b exp=%b", k,
                 {fast_busy, fast_req_ready, fast_resp_valid, fast_addr_out}, exp);
      end
      if (k == 11 || k == 12) begin
        check_count++;
        if (fast_resp_data !== 16'hBEEF)
          $display("[TB] FAIL fast_data k=%0d got=%h exp=beef", k, fast_resp_data);
        else pass_count++;
      end
    end
    check_count++;
    if (bad != 0) $display("[TB] FAIL fast_sequence got=%0d bad cycles exp=0", bad);
    else pass_count++;
  endtask

  initial begin
    pass_count  = 0;
    check_count = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 40503) ^ 16'h3C5A;
    mem[16'hA5C3] = 16'h1234;
    test_reset();
    test_basic_read();
    test_back_to_back();
    test_reset_abort();
    test_busy_ignore();
    test_random_reads();
    test_delay_one();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/ext_ram_reader.md
EXT_RAM_READER -- requirements
Module: ext_ram_reader

Interface
REQ-001 SHALL have parameter DELAY, default 7, meaning extra RAM turnaround cycles between last address nibble and first data nibble; legal range 1..31.
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  read request pending.
REQ-005 SHALL have port req_addr  input  16  word address of the request.
REQ-006 SHALL have port req_ready  output  1  block idle; request accepted when req_valid && req_ready.
REQ-007 SHALL have port addr_out  output  4  nibble stream to external serial RAM address pins.
REQ-008 SHALL have port data_in  input  4  nibble stream from external serial RAM data pins.
REQ-009 SHALL have port resp_valid  output  1  one-cycle pulse: resp_data holds a new word.
REQ-010 SHALL have port resp_data  output  16  last word read.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement states IDLE, CMD, ADDR, WAIT, DATA, RESP with one 5-bit cycle counter.
REQ-013 IDLE: req_ready=1, addr_out=4'h0; on accept (cycle T) latch req_addr, go to CMD.
REQ-014 CMD (cycle T+1): addr_out=4'h1 (read command nibble), then ADDR.
REQ-015 ADDR (cycles T+2..T+5): addr_out = req_addr[3:0], [7:4], [11:8], [15:12] in that order, then WAIT.
REQ-016 WAIT: addr_out=4'h0 for exactly DELAY cycles (T+6..T+5+DELAY), then DATA.
REQ-017 DATA (cycles T+6+DELAY..T+9+DELAY): sample data_in into resp_data bits [3:0], [7:4], [11:8], [15:12] in order; addr_out=4'h0.
REQ-018 RESP (cycle T+10+DELAY): resp_valid=1 for exactly this cycle, resp_data complete and stable; next state IDLE.
REQ-019 Total request-to-resp_valid latency SHALL be 10+DELAY cycles; next accept earliest at T+11+DELAY.
REQ-020 req_ready SHALL be 0 in all non-IDLE states; req_valid/req_addr changes while busy SHALL have no effect.
REQ-021 resp_data SHALL hold its value from RESP until the first DATA nibble of the next transaction overwrites bits [3:0]; partially updated resp_data outside RESP is not valid.
REQ-022 Address width exact 16 bits, no wrap logic: 16'hFFFF transmitted as F,F,F,F.
REQ-023 req_valid held high continuously SHALL produce back-to-back transactions separated by exactly one IDLE cycle.
REQ-024 data_in SHALL be ignored outside DATA state.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force IDLE, counter=0, addr_out=4'h0, resp_valid=0, resp_data=16'h0000, busy=0, req_ready=1 on the following cycle, from any state including mid-ADDR or mid-DATA.
REQ-026 An aborted transaction SHALL produce no resp_valid; the first accept after reset release starts a full fresh sequence at CMD.

Verification
REQ-027 DELAY=7, request 16'hA5C3 at T -> addr_out T+1..T+5 = 1,3,C,5,A; RAM returns 16'h1234 -> resp_valid only at T+17, resp_data=16'h1234.
REQ-028 req_valid held high, addrs 16'h0000 then 16'hFFFF -> second CMD nibble at T+19, second addr nibbles F,F,F,F, exactly one idle cycle between transactions.
REQ-029 rst_n pulsed low at T+3 (mid-ADDR) -> addr_out=0, busy=0 next cycle, no resp_valid ever for that request, new request then completes normally.
REQ-030 req_addr/req_valid toggled randomly while busy -> transmitted address equals value latched at accept, single resp_valid.
REQ-031 DELAY=1 parameterization, request 16'h0001 -> resp_valid at T+11; data_in driven garbage outside DATA window does not affect resp_data.
REQ-032 Bench SHALL connect block to the serial RAM model in the tb (RAM_ADDR_BITS=16, matching DELAY) and compare 256 random reads against a preloaded memory image.
